// File: rtl/semaforo_multi_if.sv
// Bus bundle for the multi-approach traffic-light controller.
// The controller sits on the slave side; the driver of requests sits on the master side.
interface semaforo_multi_if #(
  parameter int unsigned N_APPROACH = 2,
  parameter int unsigned CNT_W      = 8
);
  logic                    i_mode_night;
  logic [N_APPROACH-1:0]   i_ped_req;
  logic [CNT_W-1:0]        o_contador;
  logic [3*N_APPROACH-1:0] o_luces;
  logic [N_APPROACH-1:0]   o_walk;
  logic [1:0]              o_fase;
  logic [N_APPROACH-1:0]   o_ped_pending;

  modport master (
    output i_mode_night,
    output i_ped_req,
    input  o_contador,
    input  o_luces,
    input  o_walk,
    input  o_fase,
    input  o_ped_pending
  );

  modport slave (
    input  i_mode_night,
    input  i_ped_req,
    output o_contador,
    output o_luces,
    output o_walk,
    output o_fase,
    output o_ped_pending
  );
endinterface

// File: rtl/semaforo_multi.sv
// Round-robin traffic-light controller with pedestrian walk phase and night flashing mode.
// Lamp outputs are registered from the next-state decode so they change cleanly on the edge.
module semaforo_multi #(
  parameter int unsigned N_APPROACH = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_GREEN    = 10,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_WALK     = 6,
  parameter int unsigned T_FLASH    = 4
) (
  input  logic           i_clock,
  input  logic           i_reset,
  semaforo_multi_if.slave bus
);

  typedef enum logic [2:0] {StAllRed, StGreen, StYellow, StWalk, StFlash} state_e;

  localparam logic [CNT_W-1:0] LdGreen  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LdYellow = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LdAllRed = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LdWalk   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] LdFlash  = CNT_W'(T_FLASH - 1);
  localparam logic [1:0]       LastFase = 2'(N_APPROACH - 1);

  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_fase;
  logic                    r_flash;
  logic [N_APPROACH-1:0]   r_ped_pending;
  logic [N_APPROACH-1:0]   r_walk;
  logic [3*N_APPROACH-1:0] r_luces;

  state_e                  w_state_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [1:0]              w_fase_next;
  logic                    w_flash_next;
  logic [N_APPROACH-1:0]   w_pend_next;
  logic [N_APPROACH-1:0]   w_walk_next;
  logic [3*N_APPROACH-1:0] w_luces_next;
  logic                    w_last;

  assign w_last = (r_cnt == '0);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= StAllRed;
      r_cnt         <= LdAllRed;
      r_fase        <= 2'd0;
      r_flash       <= 1'b1;
      r_ped_pending <= '0;
      r_walk        <= '0;
      r_luces       <= {N_APPROACH{3'b100}};
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_fase        <= w_fase_next;
      r_flash       <= w_flash_next;
      r_ped_pending <= w_pend_next;
      r_walk        <= w_walk_next;
      r_luces       <= w_luces_next;
    end
  end

  // Next-state logic; r_walk doubles as the grant latched at WALK entry
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt - CNT_W'(1);
    w_fase_next  = r_fase;
    w_flash_next = r_flash;
    w_walk_next  = r_walk;
    w_pend_next  = r_ped_pending | bus.i_ped_req;
    unique case (r_state)
      StAllRed: begin
        if (w_last) begin
          if (bus.i_mode_night) begin
            w_state_next = StFlash;
            w_cnt_next   = LdFlash;
            w_flash_next = 1'b1;
          end else if (r_ped_pending != '0) begin
            w_state_next = StWalk;
            w_cnt_next   = LdWalk;
            w_walk_next  = r_ped_pending;
          end else begin
            w_state_next = StGreen;
            w_cnt_next   = LdGreen;
          end
        end
      end
      StGreen: begin
        if (w_last) begin
          w_state_next = StYellow;
          w_cnt_next   = LdYellow;
        end
      end
      StYellow: begin
        if (w_last) begin
          w_state_next = StAllRed;
          w_cnt_next   = LdAllRed;
          w_fase_next  = (r_fase == LastFase) ? 2'd0 : r_fase + 2'd1;
        end
      end
      StWalk: begin
        if (w_last) begin
          w_state_next = StGreen;
          w_cnt_next   = LdGreen;
          w_walk_next  = '0;
          // Served approaches drop everything seen up to and including this cycle
          w_pend_next  = (r_ped_pending | bus.i_ped_req) & ~r_walk;
        end
      end
      StFlash: begin
        if (w_last) begin
          if (bus.i_mode_night) begin
            w_cnt_next   = LdFlash;
            w_flash_next = ~r_flash;
          end else begin
            w_state_next = StAllRed;
            w_cnt_next   = LdAllRed;
          end
        end
      end
      default: begin
        w_state_next = StAllRed;
        w_cnt_next   = LdAllRed;
        w_walk_next  = '0;
      end
    endcase
  end

  // Lamp decode of the upcoming state, captured into r_luces
  always_comb begin
    w_luces_next = '0;
    for (int i = 0; i < N_APPROACH; i++) begin
      unique case (w_state_next)
        StGreen:  w_luces_next[3*i +: 3] = (w_fase_next == 2'(i)) ? 3'b001 : 3'b100;
        StYellow: w_luces_next[3*i +: 3] = (w_fase_next == 2'(i)) ? 3'b010 : 3'b100;
        StFlash:  w_luces_next[3*i +: 3] = {1'b0, w_flash_next, 1'b0};
        default:  w_luces_next[3*i +: 3] = 3'b100;
      endcase
    end
  end

  assign bus.o_contador    = r_cnt;
  assign bus.o_luces       = r_luces;
  assign bus.o_walk        = r_walk;
  assign bus.o_fase        = r_fase;
  assign bus.o_ped_pending = r_ped_pending;

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed plus randomized bench for semaforo_multi, checked every cycle against a
// phase/remaining-time reference model.
module tb_semaforo_multi;
  localparam int unsigned N        = 2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned T_GREEN  = 10;
  localparam int unsigned T_YELLOW = 3;
  localparam int unsigned T_ALLRED = 2;
  localparam int unsigned T_WALK   = 6;
  localparam int unsigned T_FLASH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  semaforo_multi_if #(.N_APPROACH(N), .CNT_W(CNT_W)) bus ();

  semaforo_multi #(
    .N_APPROACH(N), .CNT_W(CNT_W), .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .T_FLASH(T_FLASH)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase name and cycles still to spend in it
  string          m_phase = "allred";
  int             m_left  = T_ALLRED;
  int             m_fase  = 0;
  logic [N-1:0]   m_pend  = '0;
  logic [N-1:0]   m_grant = '0;
  logic           m_flash = 1'b1;

  task automatic enter(input string ph, input int dur);
    m_phase = ph;
    m_left  = dur;
  endtask

  task automatic model_update(input logic r, input logic night, input logic [N-1:0] req);
    logic [N-1:0] pend_new;
    if (r) begin
      enter("allred", T_ALLRED);
      m_fase = 0; m_pend = '0; m_grant = '0; m_flash = 1'b1;
      return;
    end
    pend_new = m_pend | req;
    if (m_left > 1) m_left--;
    else if (m_phase == "allred") begin
      if (night) begin enter("flash", T_FLASH); m_flash = 1'b1; end
      else if (m_pend != '0) begin enter("walk", T_WALK); m_grant = m_pend; end
      else enter("green", T_GREEN);
    end else if (m_phase == "green") enter("yellow", T_YELLOW);
    else if (m_phase == "yellow") begin
      enter("allred", T_ALLRED);
      m_fase = (m_fase + 1) % N;
    end else if (m_phase == "walk") begin
      enter("green", T_GREEN);
      pend_new = pend_new & ~m_grant;
      m_grant  = '0;
    end else begin
      if (night) begin m_left = T_FLASH; m_flash = ~m_flash; end
      else enter("allred", T_ALLRED);
    end
    m_pend = pend_new;
  endtask

  function automatic logic [3*N-1:0] exp_luces();
    logic [3*N-1:0] v;
    logic [2:0]     c;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (m_phase == "flash") c = {1'b0, m_flash, 1'b0};
      else if (m_phase == "green" && i == m_fase) c = 3'b001;
      else if (m_phase == "yellow" && i == m_fase) c = 3'b010;
      else c = 3'b100;
      v[3*i +: 3] = c;
    end
    return v;
  endfunction

  // At most one approach non-red, unless every lamp is in the flashing pattern
  function automatic logic lamps_safe(input logic [3*N-1:0] l);
    int   nonred = 0;
    logic flashy = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (l[3*i +: 3] != 3'b100) nonred++;
      if (l[3*i+2] || l[3*i]) flashy = 1'b0;
    end
    return (nonred <= 1) || flashy;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_walk;
    exp_walk = (m_phase == "walk") ? m_grant : '0;
    chk("contador", 32'(bus.o_contador), 32'(m_left - 1));
    chk("luces", 32'(bus.o_luces), 32'(exp_luces()));
    chk("walk", 32'(bus.o_walk), 32'(exp_walk));
    chk("fase", 32'(bus.o_fase), 32'(m_fase));
    chk("ped_pending", 32'(bus.o_ped_pending), 32'(m_pend));
    chk("lamps_safe", 32'(lamps_safe(bus.o_luces)), 32'd1);
  endtask

  task automatic step(input logic r, input logic night, input logic [N-1:0] req);
    rst              = r;
    bus.i_mode_night = night;
    bus.i_ped_req    = req;
    @(posedge clk);
    model_update(r, night, req);
    #1;
    check_all();
  endtask

  task automatic run_until(input string ph, input int f, input logic night,
                           input logic [N-1:0] req);
    int n = 0;
    while (!(m_phase == ph && (f < 0 || m_fase == f)) && n < 200) begin
      step(1'b0, night, req);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic night;
    logic [N-1:0] req;
    bus.i_mode_night = 1'b0;
    bus.i_ped_req    = '0;
    #2;

    // Reset wins over simultaneous requests
    step(1'b1, 1'b1, 2'b11);
    chk("rst_luces", 32'(bus.o_luces), 32'h24);
    chk("rst_contador", 32'(bus.o_contador), 32'd1);
    chk("rst_fase", 32'(bus.o_fase), 32'd0);
    chk("rst_pending", 32'(bus.o_ped_pending), 32'd0);
    step(1'b0, 1'b0, 2'b00);
    chk("allred_cnt0", 32'(bus.o_contador), 32'd0);
    step(1'b0, 1'b0, 2'b00);
    chk("green0_luces", 32'(bus.o_luces), 32'h21);
    chk("green0_cnt", 32'(bus.o_contador), 32'd9);

    // Two idle periods
    repeat (58) step(1'b0, 1'b0, 2'b00);
    run_until("green", 0, 1'b0, 2'b00);

    // Pedestrian request for approach 1 during green0
    step(1'b0, 1'b0, 2'b10);
    chk("ped_latched", 32'(bus.o_ped_pending), 32'h2);
    run_until("walk", -1, 1'b0, 2'b00);
    chk("walk_lamps", 32'(bus.o_luces), 32'h24);
    chk("walk_grant", 32'(bus.o_walk), 32'h2);
    run_until("green", -1, 1'b0, 2'b00);
    chk("after_walk_pending", 32'(bus.o_ped_pending), 32'd0);
    chk("after_walk_fase", 32'(bus.o_fase), 32'd1);
    chk("after_walk_luces", 32'(bus.o_luces), 32'h0c);

    // Night mode raised during green0 does not preempt it
    run_until("green", 0, 1'b0, 2'b00);
    run_until("flash", -1, 1'b1, 2'b00);
    chk("flash_on", 32'(bus.o_luces), 32'h12);
    repeat (4) step(1'b0, 1'b1, 2'b00);
    chk("flash_off", 32'(bus.o_luces), 32'h00);
    repeat (5) step(1'b0, 1'b1, 2'b00);
    run_until("green", -1, 1'b0, 2'b00);
    chk("after_flash_fase", 32'(bus.o_fase), 32'd1);

    // Reset mid-green1 with pending and a same-cycle request
    run_until("green", 1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b01);
    repeat (3) step(1'b0, 1'b0, 2'b00);
    step(1'b1, 1'b0, 2'b10);
    chk("midrst_pending", 32'(bus.o_ped_pending), 32'd0);
    chk("midrst_luces", 32'(bus.o_luces), 32'h24);
    chk("midrst_cnt", 32'(bus.o_contador), 32'd1);

    // Request for approach 0 held through its whole WALK
    step(1'b0, 1'b0, 2'b01);
    run_until("walk", -1, 1'b0, 2'b01);
    while (m_phase == "walk") step(1'b0, 1'b0, 2'b01);
    chk("held_pending", 32'(bus.o_ped_pending), 32'd0);
    step(1'b0, 1'b0, 2'b00);
    chk("no_second_walk", 32'(bus.o_walk), 32'd0);
    chk("green_after_walk", 32'(bus.o_luces), 32'h21);

    // Randomized traffic
    night = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) night = ~night;
      req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      step(($urandom_range(0, 399) == 0), night, req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 Parameter N_APPROACH, default 2, number of vehicle approaches served round-robin; legal range 2..4.
REQ-002 Parameter CNT_W, default 8, width of the phase countdown.
REQ-003 Parameters T_GREEN 10, T_YELLOW 3, T_ALLRED 2, T_WALK 6, T_FLASH 4, phase durations in clock cycles; each SHALL be 1..2^CNT_W.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the clock rising edge.
REQ-006 mode_night  input  1  level request for night (flashing-yellow) operation.
REQ-007 ped_req  input  N_APPROACH  per-approach pedestrian request; single-cycle pulses or held levels accepted.
REQ-008 contador  output  CNT_W  cycles remaining in the current phase, minus one.
REQ-009 luces  output  3*N_APPROACH  lamp drive; luces[3i+2:3i] = {red, yellow, green} for approach i.
REQ-010 walk  output  N_APPROACH  pedestrian walk lamp per approach.
REQ-011 fase  output  2  index of the approach currently owning (or next to own) green.
REQ-012 ped_pending  output  N_APPROACH  latched, not-yet-served pedestrian requests.

Function
REQ-013 The FSM SHALL have exactly the states ALLRED, GREEN, YELLOW, WALK and FLASH.
REQ-014 On entry to a phase, contador SHALL load T_x-1; it SHALL decrement by 1 each cycle; the phase SHALL end in the cycle contador==0, so each phase lasts exactly T_x cycles.
REQ-015 ALLRED: every approach shows red only; walk=0.
REQ-016 ALLRED exit priority: mode_night=1 -> FLASH; else ped_pending!=0 -> WALK; else -> GREEN.
REQ-017 GREEN: approach fase shows green only; all others show red; GREEN -> YELLOW.
REQ-018 YELLOW: approach fase shows yellow only; all others show red; YELLOW -> ALLRED.
REQ-019 fase SHALL increment modulo N_APPROACH on the YELLOW->ALLRED transition and at no other time.
REQ-020 WALK: all vehicle lamps show red; walk=ped_pending as latched at WALK entry; WALK -> GREEN with fase unchanged.
REQ-021 ped_pending[i] SHALL set on any cycle with ped_req[i]=1.
REQ-022 On the WALK exit cycle, ped_pending bits granted at WALK entry SHALL clear; requests arriving during WALK for granted approaches SHALL be discarded; requests for other approaches SHALL remain latched.
REQ-023 FLASH: red and green lamps are 0; every yellow bit shows a flash bit that starts at 1 and toggles each time contador reaches 0, with contador reloading T_FLASH-1.
REQ-024 FLASH exit: when contador==0 and mode_night=0, go to ALLRED with fase unchanged; ped_pending SHALL keep latching during FLASH.
REQ-025 mode_night SHALL NOT preempt GREEN, YELLOW or WALK; it takes effect only at an ALLRED exit.
REQ-026 luces and walk SHALL be registered, decoded from the registered state, with no glitch between phases.
REQ-027 At no time SHALL two approaches show non-red simultaneously, except all-yellow in FLASH.

Reset
REQ-028 While reset=1, the next clock edge SHALL set: state=ALLRED, contador=T_ALLRED-1, fase=0, ped_pending=0, walk=0, luces=all approaches red (6'b100100 for N=2), flash bit=1.
REQ-029 Reset SHALL take priority over all inputs, including a ped_req or mode_night in the same cycle.
REQ-030 Reset asserted mid-phase SHALL abandon the phase; no yellow is required before red.

Verification (defaults, N_APPROACH=2)
REQ-031 Reset one cycle -> luces=100100, contador=1, fase=0. The next 2 cycles stay ALLRED (contador 1,0). Then luces=100001, contador=9.
REQ-032 No requests -> sequence green0 10, yellow0 3 (100010), allred 2, green1 10 (001100), yellow1 3, allred 2. Period 30 cycles; fase toggles 0/1 after each yellow.
REQ-033 ped_req=2'b10 pulse during green0 -> ped_pending=10. After yellow0 and allred: WALK 6 cycles with luces=100100, walk=10. Then green1, ped_pending=00.
REQ-034 mode_night=1 raised during green0 -> green0 and yellow0 complete, then allred, then FLASH: luces alternates 010010 / 000000 every 4 cycles. Drop mode_night -> exit at the next contador==0, then allred, then green1.
REQ-035 reset pulse mid-green1 with ped_pending=01 and ped_req=10 in the same cycle -> REQ-028 state, ped_pending=00.
REQ-036 ped_req=2'b01 held through a WALK serving approach 0 -> ped_pending=00 after WALK exit, and no second WALK in the following cycle.
